seq_divider: RTL and testbench

//  Multicycle signed 32-bit integer divider for the DIV instruction. It is the responder side of the

---
 rtl/div_pkg.sv | 9 +
 rtl/div_step.sv | 23 ++
 rtl/seq_divider.sv | 133 +++++++++++++
 tb/tb_seq_divider.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizes for the sequential divider.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = $clog2(DIV_W) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] dvd_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] w_rem_sh;
  logic [WIDTH+1:0] w_diff;

  assign w_rem_sh = {rem_in, dvd_in[WIDTH-1]};
  // The extra top bit of the difference acts as the borrow: clear means rem >= divisor.
  assign w_diff   = w_rem_sh - {2'b00, divisor};
  assign q_bit    = ~w_diff[WIDTH+1];
  assign rem_out  = q_bit ? w_diff[WIDTH:0] : w_rem_sh[WIDTH:0];
  assign dvd_out  = {dvd_in[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider: remainder on hi, quotient on lo, ready pulses WIDTH+2 cycles after accept.
// Optional macro SEQ_DIVIDER_UNSIGNED_EN adds the is_unsigned input (DIVU semantics when set).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_count;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_div_zero;

  logic             w_signed;
  logic             w_b_zero;
  logic             w_accept;
  logic             w_step;
  logic             w_fix;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_dvd_nxt;
  logic             w_q_bit;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  assign w_signed = ~is_unsigned;
`else
  assign w_signed = 1'b1;
`endif

  assign w_b_zero = (b == '0);
  // Negating 0x80000000 wraps back to itself, which is the correct unsigned magnitude.
  assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_rem),
    .dvd_in  (r_dvd),
    .divisor (r_dvs),
    .rem_out (w_rem_nxt),
    .dvd_out (w_dvd_nxt),
    .q_bit   (w_q_bit)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_fix        = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = w_b_zero ? DONE : BUSY;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (r_count == CW'(WIDTH - 1)) w_next_state = FIX;
      end
      FIX: begin
        w_fix        = 1'b1;
        w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_count    <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_rem      <= '0;
        r_dvd      <= w_abs_a;
        r_dvs      <= w_abs_b;
        r_count    <= '0;
        r_sign_q   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_sign_r   <= w_signed & a[WIDTH-1];
        r_div_zero <= w_b_zero;
      end
      if (w_step) begin
        r_rem   <= w_rem_nxt;
        r_dvd   <= w_dvd_nxt | WIDTH'(w_q_bit);
        r_count <= r_count + CW'(1);
      end
      if (w_fix) begin
        r_lo <= r_sign_q ? -r_dvd : r_dvd;
        r_hi <= r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
      end
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign ready    = (r_state == DONE);
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: 64-bit arithmetic reference model, directed and random operands.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         ready;
  logic         div_zero;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  logic         is_unsigned = 1'b0;
`endif

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .start    (start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .ready    (ready),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sbq[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           ready_cnt = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: 64-bit division truncates toward zero, remainder takes the dividend's sign.
  task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic uns,
                       output exp_t e);
    longint sa, sd, q, r;
    e.acc = 0;
    if (ib == '0) begin
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      if (uns) begin
        sa = longint'({32'b0, ia});
        sd = longint'({32'b0, ib});
      end else begin
        sa = longint'($signed(ia));
        sd = longint'($signed(ib));
      end
      q = sa / sd;
      r = sa % sd;
      e.lo  = q[W-1:0];
      e.hi  = r[W-1:0];
      e.dz  = 1'b0;
      e.lat = W + 2;
      m_hi  = e.hi;
      m_lo  = e.lo;
    end
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic uns,
                       input bit push);
    exp_t e;
    model(ia, ib, uns, e);
    a     = ia;
    b     = ib;
    start = 1'b1;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    is_unsigned = uns;
`endif
    e.acc = cyc + 1;
    if (push) sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 100; i++) begin
      if (ready) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL %s: ready=%b after 100 cycles, want 1", name, ready);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && ready) begin
      ready_cnt++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: ready=1 want 0 (no request pending)");
      end else begin
        e = sbq.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_zero", W'(div_zero), W'(e.dz));
        chk("latency", W'(cyc - e.acc + 1), W'(e.lat));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] da[7];
    logic [W-1:0] db[7];
    logic [W-1:0] ra, rb;
    logic         ru;
    int           n0;
    exp_t         e;

    da = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'h80000000, 32'd0, 32'd100, 32'd9};
    db = '{32'd7,   32'd7,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'd5, 32'd7, 32'd0};

    repeat (3) @(negedge clk);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_ready", W'(ready), '0);
    chk("rst_div_zero", W'(div_zero), '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", W'(ready), '0);

    for (int i = 0; i < 7; i++) begin
      issue(da[i], db[i], 1'b0, 1'b1);
      wait_ready("directed");
    end
    repeat (3) @(negedge clk);
    chk("dz_held", W'(div_zero), W'(1));
    chk("dz_hi_held", hi, 32'd2);
    chk("dz_lo_held", lo, 32'd14);
    issue(32'd5, 32'd3, 1'b0, 1'b1);
    chk("dz_cleared", W'(div_zero), '0);
    wait_ready("after_dz");

    // start held high across most of BUSY must yield exactly one result
    @(negedge clk);
    n0 = ready_cnt;
    model(32'd1000, 32'd33, 1'b0, e);
    e.acc = cyc + 1;
    sbq.push_back(e);
    a = 32'd1000;
    b = 32'd33;
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_ready("held_start");
    repeat (5) @(negedge clk);
    chk("one_ready", W'(ready_cnt - n0), W'(1));

    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_hi", hi, '0);
    chk("midrst_lo", lo, '0);
    chk("midrst_ready", W'(ready), '0);
    chk("midrst_div_zero", W'(div_zero), '0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    n0 = ready_cnt;
    repeat (40) @(negedge clk);
    chk("midrst_no_ready", W'(ready_cnt - n0), '0);
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    wait_ready("after_reset");

`ifdef SEQ_DIVIDER_UNSIGNED_EN
    issue(32'hFFFFFFFF, 32'd2, 1'b1, 1'b1);
    wait_ready("unsigned");
    issue(32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
    wait_ready("signed_cmp");
`endif

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      ru = 1'b0;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
      ru = 1'($urandom_range(0, 1));
`endif
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: ra = 32'h80000000;
        2: rb = '1;
        3: rb = 32'($urandom_range(1, 15));
        4: rb = 32'd0 - 32'($urandom_range(1, 15));
        default: ;
      endcase
      issue(ra, rb, ru, 1'b1);
      wait_ready("random");
    end

    repeat (5) @(negedge clk);
    chk("pending", W'(sbq.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
